seven_seg_scan: RTL and testbench
=================================

// Module: seven_seg_scan
// PURPOSE
// - Time-multiplexed driver for an N-digit common-anode-select 7-segment display.
// - Holds N BCD digits in a load-strobed shadow register and scans one digit per slot:
//   drives the decoded segments together with a one-hot digit enable.
// - Sits between datapath counters and the board pins.
// - Replaces per-digit static decoders: one decoder, N digits, leading-zero blanking, anti-ghost slot.
// PARAMETERS
// - NUM_DIGITS  4  digits scanned; legal range 2..8.
// - SCAN_DIV    4  clk cycles per digit slot; legal range >=2.
// PORTS
// - clk        in   1             system clock; all state on rising edge.
// - rst        in   1             synchronous, active-high reset.
// - load       in   1             capture digits_in into the shadow register this cycle.
// - digits_in  in   4*NUM_DIGITS  BCD digits; [3:0] is digit 0 (least significant).
// - lzb        in   1             leading-zero blanking enable (level; sampled every cycle).
// - seg        out  7             segments {g,f,e,d,c,b,a}; active-high, registered.
// - an         out  NUM_DIGITS    one-hot digit enable; active-high, registered.
// - frame      out  1             1-cycle pulse when the digit index wraps NUM_DIGITS-1 -> 0.
// BEHAVIOUR
// - Reset: shadow=0, pre=0, idx=0, seg=0, an=0, frame=0 (dp=0 when enabled).
//   rst asserted mid-scan aborts the slot; state returns to these values on the next edge.
// - Prescaler: pre counts 0..SCAN_DIV-1, then wraps.
//   - Tick: pre==SCAN_DIV-1. On a tick, idx advances; it wraps NUM_DIGITS-1 -> 0.
//   - frame pulses on the cycle after a wrap tick, aligned with the first seg/an of digit 0.
// - Output registers, updated every cycle:
//   - seg <= decode(shadow[idx]) after blanking.
//   - an <= (pre==0) ? 0 : onehot(idx).
//   - pre==0 is a 1-cycle anti-ghost dead slot: seg already carries the new digit and all anodes are off.
// - Latency:
//   - First anode after rst release: an=onehot(0) on the 2nd edge.
//   - load: new data is visible on seg one edge after the load edge. No wait for a slot boundary.
// - Simultaneous load and tick: both take effect; the new idx shows the newly loaded value.
// - load held high: shadow follows digits_in every cycle.
// - Decode: 0-9 as standard; 6 includes seg a; 7 is a,b,c; 9 includes seg d.
//   Codes 10-15 show a dash (g only, 7'b1000000).
// - Leading-zero blanking (lzb=1):
//   - Digit i is blanked (seg=0) when digit i and every more-significant digit are 0.
//   - Digit 0 is never blanked; value 0 shows "0" on digit 0 only.
//   - A dash code counts as non-zero.
// - Blanking affects seg only; an still scans all digits, so brightness stays uniform.
// CONFIGURATION
// - SEVEN_SEG_DP_EN defined:
//   - Adds port dp_in (in, NUM_DIGITS): per-digit decimal point, captured with load.
//   - Adds port dp (out, 1): registered, dp <= shadow_dp[idx]; 0 on reset.
//   - A set dp suppresses leading-zero blanking for that digit and all less-significant digits.
// - SEVEN_SEG_DP_EN undefined: no dp ports, no dp state; behaviour otherwise identical.
// STRUCTURE
// - Package seven_seg_pkg:
//   - seg_t (logic [6:0]).
//   - Constants SEG_BLANK=7'h00, SEG_DASH=7'h40, SEG_DIGIT[0:9] table.
//   - Function bcd_to_seg(logic [3:0]) -> seg_t.
// - Sub-module seven_seg_decode: combinational BCD -> seg_t, one instance.
//   Blanking, scan and registers stay in seven_seg_scan.
// TESTING (NUM_DIGITS=4, SCAN_DIV=4)
// - Reset: rst=1 for 3 cycles -> seg=0, an=0, frame=0; an=4'b0001 two edges after release.
// - Scan order: load 16'h4321, lzb=0.
//   - an sequence per 4-cycle slot: 0000,0001,0001,0001, then 0000,0010...
//   - seg=digit code 1,2,3,4; frame pulses once per 16 cycles.
// - Blanking: load 16'h0050, lzb=1.
//   - Digits 3 and 2 give seg=0; digits 1 and 0 show 5 and 0.
//   - load 16'h0000 -> only digit 0 shows "0".
// - Invalid code: load 16'hF0A9 -> digit 0 shows 9; digits 1 and 3 show 7'b1000000; digit 2 shows 0.
// - Load/tick collision: assert load with 16'h8888 on a tick cycle -> the next slot shows 8 immediately.
//   Also assert rst mid-slot -> outputs return to reset values on the next edge.
// - With SEVEN_SEG_DP_EN: load 16'h0012 with dp_in=4'b0100, lzb=1.
//   - Digit 2 shows "0." (dp=1); digit 3 is blanked; dp=0 on the other digits.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types, segment constants and the BCD-to-segment helper for the
// seven-segment scan driver.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_DASH  = 7'h40;
    localparam seg_t SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Non-decimal codes render as a dash so corrupt data is visible, not silent.
    function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
        seg_t code;
        case (bcd)
            4'd0:    code = SEG_DIGIT[0];
            4'd1:    code = SEG_DIGIT[1];
            4'd2:    code = SEG_DIGIT[2];
            4'd3:    code = SEG_DIGIT[3];
            4'd4:    code = SEG_DIGIT[4];
            4'd5:    code = SEG_DIGIT[5];
            4'd6:    code = SEG_DIGIT[6];
            4'd7:    code = SEG_DIGIT[7];
            4'd8:    code = SEG_DIGIT[8];
            4'd9:    code = SEG_DIGIT[9];
            default: code = SEG_DASH;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational BCD to seven-segment decoder; one instance serves every
// scanned digit.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);

    // Pure table lookup, blanking is handled by the scanner.
    always_comb begin
        seg = bcd_to_seg(bcd);
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit seven-segment driver with leading-zero blanking
// and an anti-ghost dead slot. Optional decimal points: SEVEN_SEG_DP_EN.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
`ifdef SEVEN_SEG_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp,
`endif
    input  logic                    lzb,
    output seg_t                    seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    logic [NUM_DIGITS-1:0][3:0] shadow_r;
    logic [PW-1:0]              pre_r;
    logic [IW-1:0]              idx_r;
    logic                       wrap_r;

    logic                       tick_s;
    logic                       wrap_s;
    logic [3:0]                 digit_s;
    seg_t                       dec_seg_s;
    seg_t                       seg_next_s;
    logic [NUM_DIGITS-1:0]      onehot_s;
    logic [NUM_DIGITS-1:0]      dp_mask_s;
    logic [NUM_DIGITS-1:0]      zero_run_s;
    logic                       run_s;

`ifdef SEVEN_SEG_DP_EN
    logic [NUM_DIGITS-1:0]      shadow_dp_r;
    assign dp_mask_s = shadow_dp_r;
`else
    assign dp_mask_s = '0;
`endif

    assign tick_s   = (pre_r == PRE_LAST);
    assign wrap_s   = tick_s && (idx_r == IDX_LAST);
    assign digit_s  = shadow_r[idx_r];
    assign onehot_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r;

    seven_seg_decode u_decode (
        .bcd (digit_s),
        .seg (dec_seg_s)
    );

    // zero_run_s[i]: digit i and all more-significant digits are zero with no dp set.
    always_comb begin
        run_s      = 1'b1;
        zero_run_s = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_s         = run_s & (shadow_r[i] == 4'd0) & ~dp_mask_s[i];
            zero_run_s[i] = run_s;
        end
    end

    // Digit 0 is never blanked so an all-zero value still reads "0".
    always_comb begin
        if (lzb && (idx_r != '0) && zero_run_s[idx_r]) begin
            seg_next_s = SEG_BLANK;
        end else begin
            seg_next_s = dec_seg_s;
        end
    end

    // Shadow capture, slot prescaler, digit index and registered pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= '0;
            pre_r    <= '0;
            idx_r    <= '0;
            wrap_r   <= 1'b0;
            seg      <= SEG_BLANK;
            an       <= '0;
            frame    <= 1'b0;
`ifdef SEVEN_SEG_DP_EN
            shadow_dp_r <= '0;
            dp          <= 1'b0;
`endif
        end else begin
            if (load) begin
                shadow_r <= digits_in;
`ifdef SEVEN_SEG_DP_EN
                shadow_dp_r <= dp_in;
`endif
            end
            if (tick_s) begin
                pre_r <= '0;
                idx_r <= wrap_s ? '0 : idx_r + IW'(1);
            end else begin
                pre_r <= pre_r + PW'(1);
            end
            // Delayed one cycle so frame lines up with the first digit-0 output.
            wrap_r <= wrap_s;
            frame  <= wrap_r;
            seg    <= seg_next_s;
            an     <= (pre_r == '0) ? '0 : onehot_s;
`ifdef SEVEN_SEG_DP_EN
            dp <= shadow_dp_r[idx_r];
`endif
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed self-checking bench for seven_seg_scan (NUM_DIGITS=4, SCAN_DIV=4);
// decimal-point checks compile in with SEVEN_SEG_DP_EN.
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] digits_in;
    logic        lzb;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame;
`ifdef SEVEN_SEG_DP_EN
    logic [3:0]  dp_in;
    logic        dp;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;

    always #5 clk = ~clk;

    seven_seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .digits_in (digits_in),
`ifdef SEVEN_SEG_DP_EN
        .dp_in     (dp_in),
        .dp        (dp),
`endif
        .lzb       (lzb),
        .seg       (seg),
        .an        (an),
        .frame     (frame)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset for one edge, then load val on the first edge after release.
    // Returns just after that load edge ("edge 1"): pre=1, idx=0.
    task automatic restart(input logic [15:0] val, input logic lz, input logic [3:0] dpv);
        rst = 1'b1; load = 1'b0;
        step(1);
        rst = 1'b0; load = 1'b1; digits_in = val; lzb = lz;
`ifdef SEVEN_SEG_DP_EN
        dp_in = dpv;
`else
        if (dpv != 4'd0) $display("note: dp ignored without SEVEN_SEG_DP_EN");
`endif
        step(1);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; digits_in = 16'h0000; lzb = 1'b0;
`ifdef SEVEN_SEG_DP_EN
        dp_in = 4'b0000;
`endif
        step(3);
        check_cnt++;
        if (seg !== 7'h00) $display("FAIL reset_seg: got %h want 00", seg); else pass_cnt++;
        check_cnt++;
        if (an !== 4'b0000) $display("FAIL reset_an: got %b want 0000", an); else pass_cnt++;
        check_cnt++;
        if (frame !== 1'b0) $display("FAIL reset_frame: got %b want 0", frame); else pass_cnt++;
        rst = 1'b0;
        step(1);
        check_cnt++;
        if (an !== 4'b0000) $display("FAIL reset_first_edge_an: got %b want 0000", an); else pass_cnt++;
        check_cnt++;
        if (seg !== 7'h3F) $display("FAIL reset_first_edge_seg: got %h want 3f", seg); else pass_cnt++;
        step(1);
        check_cnt++;
        if (an !== 4'b0001) $display("FAIL reset_second_edge_an: got %b want 0001", an); else pass_cnt++;
    endtask

    // After edge k: slot digit ((k-1)/4)%4, dead slot when (k-1)%4==0, frame when k%16==1.
    task automatic test_scan_order();
        exp_seg[0] = 7'h06; exp_seg[1] = 7'h5B; exp_seg[2] = 7'h4F; exp_seg[3] = 7'h66;
        restart(16'h4321, 1'b0, 4'b0000);
        for (int k = 2; k <= 33; k++) begin
            step(1);
            exp_an = (((k - 1) % 4) == 0) ? 4'b0000 : (4'b0001 << (((k - 1) / 4) % 4));
            check_cnt++;
            if (an !== exp_an) $display("FAIL scan_an k=%0d: got %b want %b", k, an, exp_an); else pass_cnt++;
            check_cnt++;
            if (seg !== exp_seg[((k - 1) / 4) % 4])
                $display("FAIL scan_seg k=%0d: got %h want %h", k, seg, exp_seg[((k - 1) / 4) % 4]);
            else pass_cnt++;
            check_cnt++;
            if (frame !== ((k % 16) == 1))
                $display("FAIL scan_frame k=%0d: got %b want %b", k, frame, (k % 16) == 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_blanking();
        exp_seg[0] = 7'h3F; exp_seg[1] = 7'h6D; exp_seg[2] = 7'h00; exp_seg[3] = 7'h00;
        restart(16'h0050, 1'b1, 4'b0000);
        for (int k = 2; k <= 17; k++) begin
            step(1);
            exp_an = (((k - 1) % 4) == 0) ? 4'b0000 : (4'b0001 << (((k - 1) / 4) % 4));
            check_cnt++;
            if (seg !== exp_seg[((k - 1) / 4) % 4])
                $display("FAIL blank_0050_seg k=%0d: got %h want %h", k, seg, exp_seg[((k - 1) / 4) % 4]);
            else pass_cnt++;
            check_cnt++;
            if (an !== exp_an) $display("FAIL blank_0050_an k=%0d: got %b want %b", k, an, exp_an); else pass_cnt++;
        end
        exp_seg[0] = 7'h3F; exp_seg[1] = 7'h00; exp_seg[2] = 7'h00; exp_seg[3] = 7'h00;
        restart(16'h0000, 1'b1, 4'b0000);
        for (int k = 2; k <= 17; k++) begin
            step(1);
            check_cnt++;
            if (seg !== exp_seg[((k - 1) / 4) % 4])
                $display("FAIL blank_0000_seg k=%0d: got %h want %h", k, seg, exp_seg[((k - 1) / 4) % 4]);
            else pass_cnt++;
        end
    endtask

    task automatic test_invalid_code();
        exp_seg[0] = 7'h6F; exp_seg[1] = 7'h40; exp_seg[2] = 7'h3F; exp_seg[3] = 7'h40;
        restart(16'hF0A9, 1'b0, 4'b0000);
        for (int k = 2; k <= 17; k++) begin
            step(1);
            check_cnt++;
            if (seg !== exp_seg[((k - 1) / 4) % 4])
                $display("FAIL invalid_seg k=%0d: got %h want %h", k, seg, exp_seg[((k - 1) / 4) % 4]);
            else pass_cnt++;
        end
        // A dash above zeros keeps them visible under blanking.
        exp_seg[0] = 7'h3F; exp_seg[1] = 7'h3F; exp_seg[2] = 7'h40; exp_seg[3] = 7'h00;
        restart(16'h0A00, 1'b1, 4'b0000);
        for (int k = 2; k <= 17; k++) begin
            step(1);
            check_cnt++;
            if (seg !== exp_seg[((k - 1) / 4) % 4])
                $display("FAIL dash_blank_seg k=%0d: got %h want %h", k, seg, exp_seg[((k - 1) / 4) % 4]);
            else pass_cnt++;
        end
    endtask

    task automatic test_load_follow();
        restart(16'h4321, 1'b0, 4'b0000);
        load = 1'b1; digits_in = 16'h0005;
        step(1);
        check_cnt++;
        if (seg !== 7'h06) $display("FAIL follow_old_seg: got %h want 06", seg); else pass_cnt++;
        digits_in = 16'h0007;
        step(1);
        check_cnt++;
        if (seg !== 7'h6D) $display("FAIL follow_first_seg: got %h want 6d", seg); else pass_cnt++;
        step(1);
        check_cnt++;
        if (seg !== 7'h07) $display("FAIL follow_second_seg: got %h want 07", seg); else pass_cnt++;
        load = 1'b0;
    endtask

    task automatic test_collision_and_abort();
        restart(16'h4321, 1'b0, 4'b0000);
        step(2);
        load = 1'b1; digits_in = 16'h8888;
        step(1);
        load = 1'b0;
        check_cnt++;
        if (seg !== 7'h06) $display("FAIL collide_tick_seg: got %h want 06", seg); else pass_cnt++;
        step(1);
        check_cnt++;
        if (seg !== 7'h7F) $display("FAIL collide_dead_seg: got %h want 7f", seg); else pass_cnt++;
        check_cnt++;
        if (an !== 4'b0000) $display("FAIL collide_dead_an: got %b want 0000", an); else pass_cnt++;
        step(1);
        check_cnt++;
        if (an !== 4'b0010) $display("FAIL collide_slot_an: got %b want 0010", an); else pass_cnt++;
        check_cnt++;
        if (seg !== 7'h7F) $display("FAIL collide_slot_seg: got %h want 7f", seg); else pass_cnt++;
        step(1);
        rst = 1'b1;
        step(1);
        check_cnt++;
        if (seg !== 7'h00) $display("FAIL abort_seg: got %h want 00", seg); else pass_cnt++;
        check_cnt++;
        if (an !== 4'b0000) $display("FAIL abort_an: got %b want 0000", an); else pass_cnt++;
        check_cnt++;
        if (frame !== 1'b0) $display("FAIL abort_frame: got %b want 0", frame); else pass_cnt++;
        rst = 1'b0;
        step(2);
        check_cnt++;
        if (an !== 4'b0001) $display("FAIL abort_restart_an: got %b want 0001", an); else pass_cnt++;
        check_cnt++;
        if (seg !== 7'h3F) $display("FAIL abort_shadow_cleared: got %h want 3f", seg); else pass_cnt++;
    endtask

`ifdef SEVEN_SEG_DP_EN
    task automatic test_dp();
        logic exp_dp;
        exp_seg[0] = 7'h5B; exp_seg[1] = 7'h06; exp_seg[2] = 7'h3F; exp_seg[3] = 7'h00;
        restart(16'h0012, 1'b1, 4'b0100);
        for (int k = 2; k <= 17; k++) begin
            step(1);
            exp_dp = ((((k - 1) / 4) % 4) == 2);
            check_cnt++;
            if (seg !== exp_seg[((k - 1) / 4) % 4])
                $display("FAIL dp_seg k=%0d: got %h want %h", k, seg, exp_seg[((k - 1) / 4) % 4]);
            else pass_cnt++;
            check_cnt++;
            if (dp !== exp_dp) $display("FAIL dp_bit k=%0d: got %b want %b", k, dp, exp_dp); else pass_cnt++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan_order();
        test_blanking();
        test_invalid_code();
        test_load_follow();
        test_collision_and_abort();
`ifdef SEVEN_SEG_DP_EN
        test_dp();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
